// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/bubble/flush control with memory-port stalls, load-use detection and stall statistics
module hazard_controller #(
  parameter int NUM_MEM_PORTS = 2,
  parameter int LU_STAGES = 1,
  parameter int CNT_WIDTH = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_MEM_PORTS-1:0]       mem_req_i,
  input  logic [NUM_MEM_PORTS-1:0]       mem_resp_i,
  input  logic [LU_STAGES-1:0]           ld_valid_i,
  input  logic [LU_STAGES-1:0][4:0]      ld_rd_i,
  input  logic [4:0]                     ID_rs1_i,
  input  logic [4:0]                     ID_rs2_i,
  input  logic                           ID_use_rs1_i,
  input  logic                           ID_use_rs2_i,
  input  logic                           redirect_i,
  output logic                           pc_write_o,
  output logic                           if_id_write_o,
  output logic                           pipe_write_o,
  output logic                           id_bubble_o,
  output logic                           if_id_flush_o,
  output logic                           mem_stall_o,
  output logic [CNT_WIDTH-1:0]           stall_cycles_o,
  output logic [CNT_WIDTH-1:0]           lu_cycles_o,
  output logic                           timeout_o
);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, STALL, STALL_RDR} state_t;
  state_t state, state_nx;
  logic [NUM_MEM_PORTS-1:0] resp_seen, pending;
  logic [WW-1:0] wait_cnt;
  logic mem_stall, load_use, flush, lu_sel;
  // a response already seen this stall keeps its port released until the whole stall ends
  assign pending = mem_req_i & ~mem_resp_i & ~resp_seen;
  assign mem_stall = |pending;
  assign flush = (redirect_i | (state == STALL_RDR)) & ~mem_stall;
  assign lu_sel = ~mem_stall & ~flush & load_use;
  always_comb begin
    load_use = 1'b0;
    for (int k = 0; k < LU_STAGES; k++)
      load_use = load_use | (ld_valid_i[k] & (ld_rd_i[k] != 5'd0) &
                 ((ID_use_rs1_i & (ld_rd_i[k] == ID_rs1_i)) | (ID_use_rs2_i & (ld_rd_i[k] == ID_rs2_i))));
  end
  always_comb begin
    state_nx = ~mem_stall ? RUN : (redirect_i | (state == STALL_RDR)) ? STALL_RDR : STALL;
    pc_write_o = ~mem_stall & ~lu_sel;
    if_id_write_o = ~mem_stall & ~lu_sel;
    pipe_write_o = ~mem_stall;
    id_bubble_o = flush | lu_sel;
    if_id_flush_o = flush;
    mem_stall_o = mem_stall;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      resp_seen <= '0;
      stall_cycles_o <= '0;
      lu_cycles_o <= '0;
      wait_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      state <= state_nx;
      resp_seen <= mem_stall ? (resp_seen | mem_resp_i) : '0;
      stall_cycles_o <= stall_cycles_o + CNT_WIDTH'(mem_stall && !(&stall_cycles_o));
      lu_cycles_o <= lu_cycles_o + CNT_WIDTH'(lu_sel && !(&lu_cycles_o));
      wait_cnt <= mem_stall ? wait_cnt + WW'(wait_cnt != WW'(TIMEOUT)) : '0;
      timeout_o <= timeout_o | (mem_stall & (wait_cnt == WW'(TIMEOUT - 1)));
    end
  end
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors for hazard_controller with hand-computed expectations
module tb_hazard_controller;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] req = '0, resp = '0, ldv = '0;
  logic [1:0][4:0] ldrd = '0;
  logic [4:0] rs1 = '0, rs2 = '0;
  logic u1 = 1'b0, u2 = 1'b0, rdr = 1'b0;
  logic pc_w, ifid_w, pipe_w, bub, fl, stl, tmo;
  logic [3:0] st_cnt, lu_cnt;
  logic [5:0] ctl;
  int total = 0, bad = 0;
  localparam logic [5:0] IDLE = 6'b111000, STL = 6'b000001, FLS = 6'b111110, LU = 6'b001100;
  assign ctl = {pc_w, ifid_w, pipe_w, bub, fl, stl};
  always #5 clk = ~clk;
  hazard_controller #(.NUM_MEM_PORTS(2), .LU_STAGES(2), .CNT_WIDTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mem_req_i(req), .mem_resp_i(resp),
    .ld_valid_i(ldv), .ld_rd_i(ldrd), .ID_rs1_i(rs1), .ID_rs2_i(rs2),
    .ID_use_rs1_i(u1), .ID_use_rs2_i(u2), .redirect_i(rdr),
    .pc_write_o(pc_w), .if_id_write_o(ifid_w), .pipe_write_o(pipe_w),
    .id_bubble_o(bub), .if_id_flush_o(fl), .mem_stall_o(stl),
    .stall_cycles_o(st_cnt), .lu_cycles_o(lu_cnt), .timeout_o(tmo));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_ctl", ctl, IDLE);
    chk("rst_stall_cnt", st_cnt, 0);
    chk("rst_lu_cnt", lu_cnt, 0);
    chk("rst_timeout", tmo, 0);
    // I-side request answered after three stall cycles
    req = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1 chk("i_stall", ctl, STL);
      tick();
    end
    resp = 2'b01;
    #1 chk("i_release", ctl, IDLE);
    tick();
    req = '0; resp = '0;
    #1 chk("i_stall_cnt", st_cnt, 3);
    // early port-0 response must be remembered until port 1 answers
    req = 2'b11; resp = 2'b01;
    #1 chk("two_c1", ctl, STL);
    tick();
    resp = '0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("two_hold", ctl, STL);
      tick();
    end
    resp = 2'b10;
    #1 chk("two_release", ctl, IDLE);
    tick();
    req = 2'b01; resp = '0;
    #1 chk("seen_cleared", ctl, STL);
    tick();
    resp = 2'b01;
    #1 chk("seen_release", ctl, IDLE);
    tick();
    req = '0; resp = '0;
    #1 chk("two_stall_cnt", st_cnt, 7);
    // load-use in EX on rs2, then zero destination, then MEM stage on rs1
    ldv = 2'b01; ldrd[0] = 5'd5; rs1 = 5'd3; rs2 = 5'd5; u1 = 1'b1; u2 = 1'b1;
    #1 chk("lu_ex", ctl, LU);
    tick();
    chk("lu_cnt1", lu_cnt, 1);
    ldrd[0] = 5'd0; rs2 = 5'd0;
    #1 chk("lu_x0", ctl, IDLE);
    ldv = 2'b10; ldrd[0] = 5'd5; ldrd[1] = 5'd7; rs1 = 5'd7; rs2 = 5'd5;
    #1 chk("lu_mem", ctl, LU);
    tick();
    chk("lu_cnt2", lu_cnt, 2);
    u1 = 1'b0;
    #1 chk("lu_unused", ctl, IDLE);
    ldv = '0;
    // redirect during a D-side stall is deferred to the release cycle
    req = 2'b10;
    #1 chk("rdr_c1", ctl, STL);
    tick();
    rdr = 1'b1;
    #1 chk("rdr_c2", ctl, STL);
    tick();
    rdr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("rdr_hold", ctl, STL);
      tick();
    end
    resp = 2'b10;
    #1 chk("rdr_release", ctl, FLS);
    tick();
    req = '0; resp = '0;
    #1 chk("rdr_after", ctl, IDLE);
    chk("rdr_stall_cnt", st_cnt, 11);
    // redirect beats a simultaneous load-use hit
    ldv = 2'b01; ldrd[0] = 5'd9; rs1 = 5'd9; u1 = 1'b1; rdr = 1'b1;
    #1 chk("rdr_lu", ctl, FLS);
    tick();
    chk("rdr_lu_cnt", lu_cnt, 2);
    rdr = 1'b0; ldv = '0;
    #1 chk("rdr_lu_done", ctl, IDLE);
    // reset mid-stall drops the deferred redirect
    req = 2'b01; rdr = 1'b1;
    tick();
    rdr = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; req = '0;
    #1 chk("rst_drop", ctl, IDLE);
    chk("rst_cnt", st_cnt, 0);
    tick();
    chk("rst_drop_next", ctl, IDLE);
    // unanswered request trips the watchdog after eight stall cycles
    req = 2'b01;
    for (int i = 0; i < 8; i++) begin
      #1 chk("wd_pre", tmo, 0);
      tick();
    end
    chk("wd_set", tmo, 1);
    chk("wd_cnt8", st_cnt, 8);
    for (int i = 0; i < 10; i++) tick();
    chk("stall_sat", st_cnt, 15);
    resp = 2'b01;
    #1 chk("wd_release", ctl, IDLE);
    tick();
    req = '0; resp = '0;
    #1 chk("wd_sticky", tmo, 1);
    chk("sat_hold", st_cnt, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 chk("wd_rst", tmo, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_controller.md
# hazard_controller

Parametrised pipeline hazard and stall controller for the rv32i pipeline: the next generation of the single-cycle combinational hazard detector. It merges N memory-port stalls with per-port response capture, multi-stage load-use detection and a redirect flush that is held across memory stalls. It also keeps saturating stall statistics and a memory-stall watchdog. It sits beside the IF/ID/EX/MEM/WB registers and drives their write, bubble and flush controls.

## Interface
Parameters:
- NUM_MEM_PORTS, 2, number of memory ports (port 0 = I-side, 1 = D-side, more for future ports)
- LU_STAGES, 1, number of stages after ID checked for load-use (index 0 = EX, 1 = MEM, ...)
- CNT_WIDTH, 32, width of statistics counters
- TIMEOUT, 4096, consecutive memory-stall cycles before timeout_o sets (>= 2)

Ports (clock is clk and reset is rst; one clock; rst is synchronous, active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req_i  in  NUM_MEM_PORTS  port p has a read or write request asserted
- mem_resp_i  in  NUM_MEM_PORTS  port p response, 1-cycle pulse
- ld_valid_i  in  LU_STAGES  stage k holds a load
- ld_rd_i  in  LU_STAGES x 5  stage k load destination (rv32i_reg)
- ID_rs1_i, ID_rs2_i  in  5 each  ID source registers
- ID_use_rs1_i, ID_use_rs2_i  in  1 each  ID instruction reads rs1 / rs2
- redirect_i  in  1  EX taken branch/jump, 1-cycle pulse
- pc_write_o  out  1  PC register enable
- if_id_write_o  out  1  IF/ID register enable
- pipe_write_o  out  1  enable for ID/EX and all later stage registers
- id_bubble_o  out  1  1 = controlmux::zero into ID/EX, 0 = controlmux::norm
- if_id_flush_o  out  1  clear IF/ID to NOP
- mem_stall_o  out  1  global memory freeze
- stall_cycles_o  out  CNT_WIDTH  memory-stall cycle count
- lu_cycles_o  out  CNT_WIDTH  load-use bubble count
- timeout_o  out  1  sticky watchdog flag

## Operation
- pending[p] = mem_req_i[p] & ~mem_resp_i[p] & ~resp_seen[p]; mem_stall = OR of pending.
- resp_seen[p] register: set when mem_resp_i[p] & mem_stall; all bits cleared on any cycle with mem_stall = 0. An early response on one port is not lost while another port is still waiting.
- load_use = OR over k of ld_valid_i[k] & (ld_rd_i[k] != 0) & ((ID_use_rs1_i & ld_rd_i[k] == ID_rs1_i) | (ID_use_rs2_i & ld_rd_i[k] == ID_rs2_i)).
- flush = (redirect_i | rdr_pend) & ~mem_stall.
- Output priority:
  - mem_stall: all writes 0, no bubble, no flush.
  - Else flush: pc_write = if_id_write = pipe_write = 1, if_id_flush = 1, id_bubble = 1. The load-use stall is suppressed because the ID instruction is wrong-path.
  - Else load_use: pc_write = if_id_write = 0, pipe_write = 1, id_bubble = 1.
  - Else all writes 1, bubble and flush 0.
- FSM (state register), states RUN, STALL, STALL_RDR:
  - RUN: mem_stall & redirect_i -> STALL_RDR; mem_stall -> STALL; else stay.
  - STALL: redirect_i -> STALL_RDR; ~mem_stall -> RUN.
  - STALL_RDR: ~mem_stall -> RUN, with the flush applied in that release cycle.
  - rdr_pend = (state == STALL_RDR).
- Counters saturate at all-ones and do not wrap:
  - stall_cycles increments on each mem_stall cycle.
  - lu_cycles increments on each cycle where the load_use branch is selected.
- Watchdog: wait_cnt, clog2(TIMEOUT+1) bits, increments on mem_stall and clears to 0 when mem_stall = 0. When wait_cnt reaches TIMEOUT - 1 with mem_stall still high, timeout_o sets and stays set until rst.

## Timing
- All control outputs are combinational from inputs and registered state, with zero-cycle latency.
- resp_seen, state, counters, wait_cnt and timeout update on the rising clk edge.
- Reset (synchronous): state = RUN, resp_seen = 0, counters = 0, wait_cnt = 0, timeout_o = 0.
  - Control outputs then follow inputs combinationally; with idle inputs they are pc_write = if_id_write = pipe_write = 1, others 0.
- rst mid-stall drops any pending redirect and captured responses.
- Simultaneous events:
  - redirect_i and load_use in the same cycle with no mem stall: flush wins and the lu counter does not increment.
  - redirect_i while mem_stall: the redirect is deferred to the first cycle with mem_stall = 0.
  - A response on the last pending port: mem_stall falls in that same cycle.

## Test plan
- Port 0 req with resp after 3 cycles, port 1 idle -> mem_stall_o = 1 for 3 cycles with all writes 0; stall_cycles_o = 3.
- Port 0 resp at cycle 1, port 1 resp at cycle 4 -> stall held through cycle 3, resp_seen[0] = 1 during cycles 2-3, release at cycle 4, resp_seen clears at cycle 5.
- ld_valid_i[0] = 1, ld_rd_i[0] = 5, ID_rs2_i = 5, ID_use_rs2_i = 1 -> pc_write_o = 0, if_id_write_o = 0, id_bubble_o = 1, pipe_write_o = 1; lu_cycles_o = 1. Same stimulus with ld_rd_i[0] = 0 -> no stall.
- redirect_i pulses during a 4-cycle D-side stall -> if_id_flush_o = 1 and id_bubble_o = 1 exactly in the release cycle, then state returns to RUN.
- redirect_i together with a load-use hit -> flush asserted, pc_write_o = 1, lu_cycles_o unchanged.
- TIMEOUT = 8, request never answered -> timeout_o rises after the 8th stall cycle and stays 1 after the resp arrives, until rst.
